// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction fetch stage feeding the SISC controller.
// Owns the program counter and instruction register, runs a single
// outstanding req/ack read to instruction memory, and applies absolute or
// relative branch updates to the PC while no fetch is in flight.
module sisc_fetch #(
   parameter int ADDR_W   = 16,
   parameter int INSTR_W  = 32,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               fetch_req,
   output logic               fetch_done,
   output logic               busy,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               br_load,
   input  logic               br_taken,
   input  logic               br_rel,
   input  logic [ADDR_W-1:0]  br_imm,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [ADDR_W-1:0]  pc,
   output logic               br_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic               br_err_q;

   // State register; reset abandons any outstanding fetch immediately.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: one fetch at a time, requests while busy are dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fetch_req) state_nxt = REQ;
         REQ:     if (imem_ack)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // PC, IR and sticky branch error. Branches are only honoured in IDLE, so
   // a same-cycle fetch_req reads from the branched PC on the next cycle.
   // The relative base is the already-incremented PC (next instruction).
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc_q     <= ADDR_W'(RESET_PC);
         ir_q     <= '0;
         br_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (br_load && br_taken) begin
                  pc_q <= br_rel ? (pc_q + br_imm) : br_imm;
               end
            end
            REQ: begin
               if (br_load) begin
                  br_err_q <= 1'b1;
               end
               if (imem_ack) begin
                  ir_q <= imem_rdata;
                  pc_q <= pc_q + ADDR_W'(1);
               end
            end
            DONE: begin
               if (br_load) begin
                  br_err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      imem_req   = (state == REQ);
      fetch_done = (state == DONE);
      busy       = (state != IDLE);
      imem_addr  = pc_q;
      pc         = pc_q;
      instr      = ir_q;
      opcode     = ir_q[INSTR_W-1 -: 4];
      mm         = ir_q[INSTR_W-5 -: 4];
      br_err     = br_err_q;
   end

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: directed-vector bench for sisc_fetch.
module tb_sisc_fetch;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 32;

   logic               clk;
   logic               rst_f;
   logic               fetch_req;
   logic               fetch_done;
   logic               busy;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               br_load;
   logic               br_taken;
   logic               br_rel;
   logic [ADDR_W-1:0]  br_imm;
   logic [INSTR_W-1:0] instr;
   logic [3:0]         opcode;
   logic [3:0]         mm;
   logic [ADDR_W-1:0]  pc;
   logic               br_err;

   int tests_run;
   int tests_failed;

   sisc_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .fetch_req  (fetch_req),
      .fetch_done (fetch_done),
      .busy       (busy),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .br_load    (br_load),
      .br_taken   (br_taken),
      .br_rel     (br_rel),
      .br_imm     (br_imm),
      .instr      (instr),
      .opcode     (opcode),
      .mm         (mm),
      .pc         (pc),
      .br_err     (br_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled and inputs driven 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic branch(input logic taken, input logic rel, input logic [ADDR_W-1:0] imm);
      br_load  = 1'b1;
      br_taken = taken;
      br_rel   = rel;
      br_imm   = imm;
      step();
      br_load  = 1'b0;
      br_taken = 1'b0;
      br_rel   = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_f      = 1'b0;
      fetch_req  = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      br_load    = 1'b0;
      br_taken   = 1'b0;
      br_rel     = 1'b0;
      br_imm     = '0;

      // Reset state
      #3;
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_imem_req", 32'(imem_req), 32'h0);
      check("rst_fetch_done", 32'(fetch_done), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_br_err", 32'(br_err), 32'h0);
      step();
      step();
      rst_f = 1'b1;
      step();

      // Zero-wait fetch
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("t1_imem_req", 32'(imem_req), 32'h1);
      check("t1_imem_addr", 32'(imem_addr), 32'h0);
      check("t1_busy", 32'(busy), 32'h1);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1A00_0005;
      step();
      imem_ack = 1'b0;
      check("t1_fetch_done", 32'(fetch_done), 32'h1);
      check("t1_opcode", 32'(opcode), 32'h1);
      check("t1_mm", 32'(mm), 32'hA);
      check("t1_pc", 32'(pc), 32'h1);
      check("t1_instr", instr, 32'h1A00_0005);
      check("t1_req_low", 32'(imem_req), 32'h0);
      step();
      check("t1_done_pulse", 32'(fetch_done), 32'h0);
      check("t1_idle", 32'(busy), 32'h0);

      // Fetch with three wait cycles and a redundant fetch_req during REQ
      fetch_req = 1'b1;
      step();
      check("t2_req", 32'(imem_req), 32'h1);
      for (int i = 0; i < 3; i++) begin
         fetch_req = (i == 0);
         step();
         check("t2_req_held", 32'(imem_req), 32'h1);
         check("t2_addr_stable", 32'(imem_addr), 32'h1);
         check("t2_no_done", 32'(fetch_done), 32'h0);
      end
      fetch_req  = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h2B00_0000;
      step();
      imem_ack = 1'b0;
      check("t2_fetch_done", 32'(fetch_done), 32'h1);
      check("t2_opcode", 32'(opcode), 32'h2);
      check("t2_mm", 32'(mm), 32'hB);
      check("t2_pc", 32'(pc), 32'h2);
      step();
      check("t2_not_queued", 32'(busy), 32'h0);
      check("t2_pc_hold", 32'(pc), 32'h2);
      check("t2_instr_hold", instr, 32'h2B00_0000);

      // Absolute branches, taken and not taken
      branch(1'b1, 1'b0, 16'h0005);
      check("t3_abs_5", 32'(pc), 32'h5);
      branch(1'b1, 1'b0, 16'h0040);
      check("t3_abs_40", 32'(pc), 32'h40);
      branch(1'b1, 1'b0, 16'h0005);
      branch(1'b0, 1'b0, 16'h0040);
      check("t3_not_taken", 32'(pc), 32'h5);

      // Relative branches, negative offset and wrap
      branch(1'b1, 1'b0, 16'h0010);
      branch(1'b1, 1'b1, 16'hFFFC);
      check("t4_rel_neg", 32'(pc), 32'hC);
      branch(1'b1, 1'b0, 16'hFFFF);
      branch(1'b1, 1'b1, 16'h0002);
      check("t4_rel_wrap", 32'(pc), 32'h1);

      // PC increment wraps at top of address space
      branch(1'b1, 1'b0, 16'hFFFF);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
      imem_ack   = 1'b1;
      imem_rdata = 32'h3C00_0001;
      step();
      imem_ack = 1'b0;
      check("t5_pc_wrap", 32'(pc), 32'h0);
      step();

      // Branch and fetch together: fetch uses the branched PC
      br_load   = 1'b1;
      br_taken  = 1'b1;
      br_rel    = 1'b0;
      br_imm    = 16'h0100;
      fetch_req = 1'b1;
      step();
      br_load   = 1'b0;
      br_taken  = 1'b0;
      fetch_req = 1'b0;
      check("t6_req", 32'(imem_req), 32'h1);
      check("t6_addr", 32'(imem_addr), 32'h100);
      imem_ack   = 1'b1;
      imem_rdata = 32'h4D00_0000;
      step();
      imem_ack = 1'b0;
      check("t6_pc", 32'(pc), 32'h101);
      check("t6_br_err", 32'(br_err), 32'h0);
      step();

      // Branch while busy: ignored, sticky error set
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      branch(1'b1, 1'b0, 16'h0077);
      check("t7_pc_unchanged", 32'(pc), 32'h101);
      check("t7_br_err", 32'(br_err), 32'h1);
      check("t7_still_req", 32'(imem_req), 32'h1);
      imem_ack   = 1'b1;
      imem_rdata = 32'h5E00_0000;
      step();
      imem_ack = 1'b0;
      check("t7_done", 32'(fetch_done), 32'h1);
      check("t7_pc_inc", 32'(pc), 32'h102);
      check("t7_opcode", 32'(opcode), 32'h5);
      step();
      check("t7_err_sticky", 32'(br_err), 32'h1);

      // Asynchronous reset in REQ, then a stray ack after release
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("t8_req_before", 32'(imem_req), 32'h1);
      #2;
      rst_f = 1'b0;
      #1;
      check("t8_req_reset", 32'(imem_req), 32'h0);
      check("t8_pc_reset", 32'(pc), 32'h0);
      check("t8_instr_reset", instr, 32'h0);
      check("t8_err_reset", 32'(br_err), 32'h0);
      step();
      rst_f      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h6F00_0000;
      step();
      check("t8_no_done", 32'(fetch_done), 32'h0);
      check("t8_instr_keep", instr, 32'h0);
      check("t8_idle", 32'(busy), 32'h0);
      step();
      imem_ack = 1'b0;
      check("t8_no_done2", 32'(fetch_done), 32'h0);
      check("t8_pc_keep", 32'(pc), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction fetch stage directly upstream of the SISC control FSM.
- Owns the program counter (PC) and the instruction register (IR).
- Fetches one instruction from instruction memory through a req/ack handshake and presents opcode and mm fields to the controller.
- Applies absolute and relative branch updates to the PC on request from the controller.

Parameters:
- ADDR_W, 16, PC / instruction memory address width.
- INSTR_W, 32, instruction width; opcode = IR[INSTR_W-1 -: 4], mm = IR[INSTR_W-5 -: 4].
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_f  input  1  asynchronous active-low reset.
- fetch_req  input  1  controller pulse in fetch state: start one fetch.
- fetch_done  output  1  one-cycle pulse: IR holds the new instruction.
- busy  output  1  high while a fetch is outstanding (REQ or DONE state).
- imem_req  output  1  memory read request.
- imem_addr  output  ADDR_W  read address, equal to PC while imem_req=1.
- imem_ack  input  1  memory data valid this cycle.
- imem_rdata  input  INSTR_W  memory read data.
- br_load  input  1  controller pulse: apply a branch this cycle.
- br_taken  input  1  branch condition result, qualified by br_load.
- br_rel  input  1  1 = relative branch (BRR/BNR), 0 = absolute (BRA/BNE).
- br_imm  input  ADDR_W  branch target or signed offset.
- instr  output  INSTR_W  IR contents.
- opcode  output  4  IR opcode field.
- mm  output  4  IR mm field.
- pc  output  ADDR_W  current PC.
- br_err  output  1  sticky flag: br_load arrived while busy.

Behaviour:
- Reset (async, rst_f=0):
  - state=IDLE, pc=RESET_PC, instr=0 (NOOP), imem_req=0, fetch_done=0, busy=0, br_err=0.
  - Takes effect immediately, including mid-fetch. An ack arriving after reset release with no outstanding request is ignored.
- FSM states: IDLE, REQ, DONE.
  - IDLE: fetch_req=1 -> REQ. Otherwise stay.
  - REQ: imem_req=1, imem_addr=pc. When imem_ack=1 on a posedge: instr<=imem_rdata, pc<=pc+1 (mod 2^ADDR_W), -> DONE. Otherwise stay; there is no timeout.
  - DONE: fetch_done=1, imem_req=0 -> IDLE.
- Latency: fetch_req at cycle N, imem_req high from N+1. A zero-wait ack at N+1 gives fetch_done high during N+2 with the new opcode/mm valid. Each wait cycle adds one.
- fetch_req while busy is ignored; it is not queued.
- imem_ack in IDLE or DONE is ignored.
- Branch handling, honoured only in IDLE:
  - br_load=1 and br_taken=1: pc<=br_rel ? pc+br_imm (two's complement, wrap mod 2^ADDR_W) : br_imm.
  - br_taken=0: pc unchanged.
- The relative base is the already-incremented PC, i.e. the address of the next instruction.
- br_load while busy: PC unchanged and br_err<=1. br_err is cleared only by reset.
- br_load and fetch_req together in IDLE: the branch applies first, and the fetch then uses the branched PC. pc is registered at the edge and REQ drives the new value.
- pc wrap: 2^ADDR_W-1 +1 -> 0, with no flag.
- opcode, mm and instr are held stable between fetch_done pulses. HLT is not interpreted here.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.

Test Plan:
- Reset then fetch_req, ack zero-wait with rdata=0x1A00_0005 -> imem_addr=0 in cycle N+1; fetch_done in N+2; opcode=1, mm=0xA, pc=1.
- Fetch with ack delayed 3 cycles -> imem_req held 3+1 cycles, addr stable; fetch_done one cycle after ack; second fetch_req during REQ has no effect.
- pc=5, br_load, br_taken=1, br_rel=0, br_imm=0x0040 -> pc=0x0040. Same with br_taken=0 -> pc=5.
- pc=0x0010, br_rel=1, br_imm=0xFFFC (-4) -> pc=0x000C. pc=0xFFFF, br_imm=2 relative -> pc=0x0001.
- br_load during REQ -> pc unchanged, br_err=1, fetch completes normally with pc+1.
- rst_f low while in REQ -> imem_req=0 immediately, pc=RESET_PC, instr=0. A late ack after release produces no fetch_done and no IR change.
